// File: rtl/cbc_stream_engine_pkg.sv
// Shared types, sizes and PRESENT round helpers for the CBC stream engine.
// The 16-bit PRESENT variant uses four nibble S-boxes and a 20-bit key.
package cbc_pkg;

    localparam int BLOCK_W = 16;
    localparam int KEY_W   = 20;
    localparam int ROUNDS  = 8;

    // Nibble i of each table is the substitution of value i.
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

    typedef enum logic {
        CBC_ENC = 1'b0,
        CBC_DEC = 1'b1
    } cbc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } cbc_state_e;

    function automatic logic [3:0] nib(input logic [3:0] n, input logic [63:0] tbl);
        return tbl[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_nibbles(input logic [BLOCK_W-1:0] x,
                                                       input logic [63:0] tbl);
        return {nib(x[15:12], tbl), nib(x[11:8], tbl),
                nib(x[7:4], tbl), nib(x[3:0], tbl)};
    endfunction

    // Bit i moves to 4*i mod 15 (bit 15 fixed); the map is its own inverse.
    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
        return {x[15], x[11], x[7], x[3], x[14], x[10], x[6], x[2],
                x[13], x[9], x[5], x[1], x[12], x[8], x[4], x[0]};
    endfunction

    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [3:0] rc);
        logic [KEY_W-1:0] n;
        n        = {k[12:0], k[19:13]};
        n[19:16] = nib(n[19:16], SBOX);
        n[3:0]   = n[3:0] ^ rc;
        return n;
    endfunction

    function automatic logic [KEY_W-1:0] key_revert(input logic [KEY_W-1:0] k,
                                                    input logic [3:0] rc);
        logic [KEY_W-1:0] m;
        m        = k;
        m[3:0]   = m[3:0] ^ rc;
        m[19:16] = nib(m[19:16], SBOX_INV);
        return {m[6:0], m[19:7]};
    endfunction

endpackage

// File: rtl/cbc_stream_engine_if.sv
// Configuration, input-stream and output-stream bundle of the CBC engine.
// The master side drives messages and blocks; the engine is the slave.
interface cbc_stream_engine_if
    import cbc_pkg::*;
#(
    parameter int MAX_BLOCKS = 8,
    parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_mode;
    logic [BLOCK_W-1:0] cfg_iv;
    logic [KEY_W-1:0]   cfg_key;
    logic [CNT_W-1:0]   cfg_len;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               out_last;
    logic               busy;
    logic               done;

    modport master (
        output cfg_valid, cfg_mode, cfg_iv, cfg_key, cfg_len, abort,
        output in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_iv, cfg_key, cfg_len, abort,
        input  in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/cbc_stream_engine_block_unit.sv
// Combinational CBC step: PRESENT encrypt/decrypt cores plus chain XORs.
// Returns the output block and the chain value for the next block.
module present_cipher
    import cbc_pkg::*;
(
    input  logic [KEY_W-1:0]   key_i,
    input  logic [BLOCK_W-1:0] pt_i,
    output logic [BLOCK_W-1:0] ct_o
);
    always_comb begin
        logic [KEY_W-1:0]   k;
        logic [BLOCK_W-1:0] s;
        k = key_i;
        s = pt_i;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = p_layer(sub_nibbles(s ^ k[KEY_W-1 -: BLOCK_W], SBOX));
            k = key_update(k, 4'(r));
        end
        ct_o = s ^ k[KEY_W-1 -: BLOCK_W];
    end
endmodule

module present_decipher
    import cbc_pkg::*;
(
    input  logic [KEY_W-1:0]   key_i,
    input  logic [BLOCK_W-1:0] ct_i,
    output logic [BLOCK_W-1:0] pt_o
);
    // Run the schedule forward to the last key, then unwind it per round.
    always_comb begin
        logic [KEY_W-1:0]   k;
        logic [BLOCK_W-1:0] s;
        k = key_i;
        for (int r = 1; r <= ROUNDS; r++) begin
            k = key_update(k, 4'(r));
        end
        s = ct_i ^ k[KEY_W-1 -: BLOCK_W];
        for (int r = ROUNDS; r >= 1; r--) begin
            k = key_revert(k, 4'(r));
            s = sub_nibbles(p_layer(s), SBOX_INV) ^ k[KEY_W-1 -: BLOCK_W];
        end
        pt_o = s;
    end
endmodule

module cbc_block_unit
    import cbc_pkg::*;
(
    input  cbc_mode_e          mode_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [BLOCK_W-1:0] chain_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] y_o,
    output logic [BLOCK_W-1:0] chain_o
);
    logic [BLOCK_W-1:0] enc_y;
    logic [BLOCK_W-1:0] dec_x;

    present_cipher u_enc (
        .key_i (key_i),
        .pt_i  (data_i ^ chain_i),
        .ct_o  (enc_y)
    );

    present_decipher u_dec (
        .key_i (key_i),
        .ct_i  (data_i),
        .pt_o  (dec_x)
    );

    always_comb begin
        y_o     = enc_y;
        chain_o = enc_y;
        unique case (mode_i)
            CBC_ENC: begin
                y_o     = enc_y;
                chain_o = enc_y;
            end
            CBC_DEC: begin
                y_o     = dec_x ^ chain_i;
                chain_o = data_i;
            end
        endcase
    end
endmodule

// File: rtl/cbc_stream_engine.sv
// CBC stream engine top: message FSM, block counter and output register.
// One block per input handshake through a combinational PRESENT datapath.
module cbc_stream_engine
    import cbc_pkg::*;
#(
    parameter int MAX_BLOCKS = 8,
    parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
    input logic clk,
    input logic rst_n,
    cbc_stream_engine_if.slave bus_if
);
    cbc_state_e         state_q, state_d;
    cbc_mode_e          mode_q, mode_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]   len_q, len_d, blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0]   len_clamped;
    logic [BLOCK_W-1:0] chain_q, chain_d, out_data_q, out_data_d;
    logic [BLOCK_W-1:0] blk_y, blk_chain;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic               cfg_hs, in_hs, out_hs, last_blk;

    assign len_clamped = (bus_if.cfg_len > CNT_W'(MAX_BLOCKS)) ?
                         CNT_W'(MAX_BLOCKS) : bus_if.cfg_len;
    assign cfg_hs   = bus_if.cfg_valid && bus_if.cfg_ready;
    assign in_hs    = bus_if.in_valid && bus_if.in_ready;
    assign out_hs   = out_valid_q && bus_if.out_ready;
    assign last_blk = (blk_cnt_q == len_q - CNT_W'(1));

    cbc_block_unit u_blk (
        .mode_i  (mode_q),
        .key_i   (key_q),
        .chain_i (chain_q),
        .data_i  (bus_if.in_data),
        .y_o     (blk_y),
        .chain_o (blk_chain)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cfg_hs && len_clamped != '0) state_d = ST_RUN;
            ST_RUN:   if (in_hs && last_blk) state_d = ST_DRAIN;
            ST_DRAIN: if (out_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (bus_if.abort) state_d = ST_IDLE;
    end

    // Handshake readiness is decoded from state; in_ready also sees out_ready.
    always_comb begin
        bus_if.cfg_ready = 1'b0;
        bus_if.in_ready  = 1'b0;
        bus_if.busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                bus_if.cfg_ready = 1'b1;
                bus_if.busy      = 1'b0;
            end
            ST_RUN:   bus_if.in_ready = !out_valid_q || bus_if.out_ready;
            ST_DRAIN: bus_if.in_ready = 1'b0;
            default:  bus_if.busy = 1'b0;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        key_d       = key_q;
        len_d       = len_q;
        chain_d     = chain_q;
        blk_cnt_d   = blk_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        if (cfg_hs) begin
            mode_d    = cbc_mode_e'(bus_if.cfg_mode);
            key_d     = bus_if.cfg_key;
            len_d     = len_clamped;
            chain_d   = bus_if.cfg_iv;
            blk_cnt_d = '0;
            done_d    = (len_clamped == '0);
        end
        if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (in_hs) begin
            chain_d     = blk_chain;
            out_data_d  = blk_y;
            out_valid_d = 1'b1;
            out_last_d  = last_blk;
            blk_cnt_d   = blk_cnt_q + CNT_W'(1);
        end
        if (out_hs && state_q == ST_DRAIN) done_d = 1'b1;
        if (bus_if.abort) begin
            chain_d     = '0;
            blk_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= CBC_ENC;
            key_q       <= '0;
            len_q       <= '0;
            chain_q     <= '0;
            blk_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            key_q       <= key_d;
            len_q       <= len_d;
            chain_q     <= chain_d;
            blk_cnt_q   <= blk_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_data_q;
    assign bus_if.out_last  = out_last_q;
    assign bus_if.done      = done_q;

endmodule

// File: tb/tb_cbc_stream_engine.sv
// Directed bench for cbc_stream_engine with a bit-level PRESENT/CBC model.
// Covers full flow, round trip, backpressure, length limits, abort, reset.
module tb_cbc_stream_engine;
    import cbc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cbc_stream_engine_if #(.MAX_BLOCKS(8)) bus ();

    cbc_stream_engine #(.MAX_BLOCKS(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [15:0] got[$];
    logic        got_last[$];
    int          got_cyc[$];
    bit          rdy_toggle = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    int sb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    int isb[16];

    task automatic check(input string tag, input logic [31:0] got_v,
                         input logic [31:0] exp_v);
        n_chk++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got_v, exp_v, $time);
    endtask

    function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
        logic [15:0] y;
        for (int j = 0; j < 4; j++)
            y[j*4 +: 4] = 4'(inv ? isb[x[j*4 +: 4]] : sb[x[j*4 +: 4]]);
        return y;
    endfunction

    function automatic logic [15:0] m_perm(input logic [15:0] x);
        logic [15:0] y;
        for (int i = 0; i < 16; i++) y[(i == 15) ? 15 : (i * 4) % 15] = x[i];
        return y;
    endfunction

    function automatic logic [8:0][15:0] m_keys(input logic [19:0] key);
        logic [8:0][15:0] rk;
        logic [19:0] k;
        k = key;
        for (int r = 0; r < 9; r++) begin
            rk[r] = k[19:4];
            k = {k[12:0], k[19:13]};
            k[19:16] = 4'(sb[k[19:16]]);
            k[3:0] = k[3:0] ^ 4'(r + 1);
        end
        return rk;
    endfunction

    function automatic logic [15:0] m_enc(input logic [15:0] x, input logic [19:0] key);
        logic [8:0][15:0] rk;
        logic [15:0] s;
        rk = m_keys(key);
        s = x;
        for (int r = 0; r < 8; r++) s = m_perm(m_sub(s ^ rk[r], 0));
        return s ^ rk[8];
    endfunction

    function automatic logic [15:0] m_dec(input logic [15:0] y, input logic [19:0] key);
        logic [8:0][15:0] rk;
        logic [15:0] s;
        rk = m_keys(key);
        s = y ^ rk[8];
        for (int r = 7; r >= 0; r--) s = m_sub(m_perm(s), 1) ^ rk[r];
        return s;
    endfunction

    function automatic void ref_cbc(input logic dec, input logic [15:0] iv,
                                    input logic [19:0] key, input logic [15:0] x[$],
                                    output logic [15:0] y[$]);
        logic [15:0] c;
        c = iv;
        y = {};
        foreach (x[i]) begin
            if (dec) begin
                y.push_back(m_dec(x[i], key) ^ c);
                c = x[i];
            end else begin
                c = m_enc(x[i] ^ c, key);
                y.push_back(c);
            end
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
                check("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready && !bus.abort) begin
                got.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                got_cyc.push_back(cyc);
            end
        end
        prev_stall = rst_n && bus.out_valid && !bus.out_ready && !bus.abort;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
    end

    always @(posedge clk) begin
        if (rdy_toggle) begin
            #1;
            bus.out_ready = ~bus.out_ready;
        end
    end

    task automatic do_cfg(input logic dec, input logic [15:0] iv,
                          input logic [19:0] key, input logic [3:0] len);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = dec;
        bus.cfg_iv    = iv;
        bus.cfg_key   = key;
        bus.cfg_len   = len;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic feed(input logic [15:0] blk[$], input int n);
        bit hs;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = blk[i];
            hs = 0;
            for (int t = 0; t < 40 && !hs; t++) begin
                @(negedge clk);
                hs = bus.in_ready;
                @(posedge clk); #1;
            end
            if (!hs) begin
                check("in_handshake", hs, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            seen = bus.done;
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_got();
        got.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    task automatic run_msg(input logic dec, input logic [15:0] iv, input logic [19:0] key,
                           input logic [3:0] len, input logic [15:0] blk[$]);
        bit seen;
        int d0;
        clear_got();
        d0 = done_cnt;
        do_cfg(dec, iv, key, len);
        feed(blk, blk.size());
        wait_done(seen);
        check("done_seen", seen, 1);
        check("done_once", done_cnt - d0, 1);
        if (got_cyc.size() > 0)
            check("done_latency", done_cyc - got_cyc[got_cyc.size()-1], 1);
        check("busy_after", bus.busy, 0);
    endtask

    task automatic verify_outs(input logic [15:0] exp_q[$]);
        check("out_count", got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got.size()) begin
                check("out_data", got[i], exp_q[i]);
                check("out_last", got_last[i], i == exp_q.size() - 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ct[$], pt[$], enc_out[$], exp_q[$];
        bit seen;
        int d0;
        for (int i = 0; i < 16; i++) isb[sb[i]] = i;
        bus.cfg_valid = 0; bus.cfg_mode = 0; bus.cfg_iv = '0;
        bus.cfg_key = '0; bus.cfg_len = '0; bus.abort = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 16'h0000);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cfg_ready", bus.cfg_ready, 1);
        #5 rst_n = 1'b1;

        // Decrypt, full flow, back to back
        ct = '{16'h3A7C, 16'h0000, 16'hFFFF, 16'h1234,
               16'hBEEF, 16'h8001, 16'h5A5A, 16'hC3C3};
        run_msg(1, 16'h1234, 20'hABCDE, 8, ct);
        ref_cbc(1, 16'h1234, 20'hABCDE, ct, exp_q);
        verify_outs(exp_q);
        foreach (got_cyc[i]) check("consecutive", got_cyc[i] - got_cyc[0], i);

        // Round trip
        pt = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'hA5A5};
        run_msg(0, 16'h1234, 20'hABCDE, 5, pt);
        ref_cbc(0, 16'h1234, 20'hABCDE, pt, exp_q);
        verify_outs(exp_q);
        enc_out = got;
        run_msg(1, 16'h1234, 20'hABCDE, 5, enc_out);
        verify_outs(pt);

        // Backpressure
        pt = '{16'h1111, 16'h2222, 16'h3333};
        rdy_toggle = 1;
        run_msg(0, 16'hCAFE, 20'h13579, 3, pt);
        rdy_toggle = 0;
        #2 bus.out_ready = 1'b1;
        ref_cbc(0, 16'hCAFE, 20'h13579, pt, exp_q);
        verify_outs(exp_q);

        // Zero-length message
        clear_got();
        d0 = done_cnt;
        do_cfg(0, 16'h1234, 20'hABCDE, 0);
        @(negedge clk);
        check("len0_done", bus.done, 1);
        check("len0_cfg_ready", bus.cfg_ready, 1);
        check("len0_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("len0_no_output", got.size(), 0);
        check("len0_done_once", done_cnt - d0, 1);

        // Oversized length clamps to MAX_BLOCKS
        pt = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
               16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};
        @(posedge clk); #1;
        run_msg(0, 16'h7777, 20'h0F0F0, 15, pt);
        ref_cbc(0, 16'h7777, 20'h0F0F0, pt, exp_q);
        verify_outs(exp_q);

        // Abort after 2 of 6 blocks with a stalled output
        ct = '{16'hAAAA, 16'h5555, 16'h1357, 16'h2468, 16'h9999, 16'h6666};
        clear_got();
        do_cfg(1, 16'h4321, 20'h55555, 6);
        feed(ct, 2);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        d0 = done_cnt;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_cfg_ready", bus.cfg_ready, 1);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        ct = '{16'h0F0F, 16'hF0F0, 16'h1234, 16'hFEDC};
        run_msg(1, 16'h0F0F, 20'h55555, 4, ct);
        ref_cbc(1, 16'h0F0F, 20'h55555, ct, exp_q);
        verify_outs(exp_q);

        // Reset mid-message while an output is pending
        pt = '{16'hDEAD, 16'hBEEF};
        do_cfg(0, 16'h1111, 20'h22222, 4);
        feed(pt, 1);
        bus.out_ready = 1'b0;
        @(posedge clk); #3;
        check("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 16'h0000);
        check("arst_out_last", bus.out_last, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        #13 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_cfg_ready", bus.cfg_ready, 1);
        check("post_rst_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
